// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: two-port round-robin controller for a byte-wide,
// single-ported data memory. Multi-byte accesses are serialised one byte
// per cycle, most significant byte at the lowest address.
module data_mem_arbiter #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    // port 0: pipeline MEM stage
    input  logic              p0_req_i,
    input  logic              p0_we_i,
    input  logic [1:0]        p0_size_i,
    input  logic [31:0]       p0_addr_i,
    input  logic [31:0]       p0_wdata_i,
    output logic              p0_ack_o,
    output logic              p0_err_o,
    output logic [31:0]       p0_rdata_o,
    // port 1: debug / loader
    input  logic              p1_req_i,
    input  logic              p1_we_i,
    input  logic [1:0]        p1_size_i,
    input  logic [31:0]       p1_addr_i,
    input  logic [31:0]       p1_wdata_i,
    output logic              p1_ack_o,
    output logic              p1_err_o,
    output logic [31:0]       p1_rdata_o,
    // byte memory
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_we_o,
    output logic [7:0]        mem_wdata_o,
    input  logic [7:0]        mem_rdata_i,
    output logic              busy_o
);

    typedef enum logic [1:0] {IDLE, XFER, RTAIL, DONE} state_t;

    state_t              state_q, state_d;
    logic                gnt_q;      // port currently being served
    logic                last_q;     // port granted most recently
    logic                we_q;
    logic                err_q;
    logic [2:0]          n_q;        // transfer length in bytes: 1, 2 or 4
    logic [1:0]          cnt_q;      // byte index within the transfer
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;

    logic                req_any;
    logic                sel;
    logic                sel_we;
    logic [1:0]          sel_size;
    logic [31:0]         sel_addr;
    logic [31:0]         sel_wdata;
    logic [2:0]          sel_n;
    logic [32:0]         sel_end;
    logic                sel_err;
    logic                xfer_last;
    logic [1:0]          byte_idx;

    assign req_any = p0_req_i | p1_req_i;

    // Pick a port (round-robin on a tie) and decode its request fields
    always_comb begin
        sel = 1'b0;
        if (p0_req_i && p1_req_i) begin
            sel = ~last_q;
        end else if (p1_req_i) begin
            sel = 1'b1;
        end
        sel_we    = sel ? p1_we_i    : p0_we_i;
        sel_size  = sel ? p1_size_i  : p0_size_i;
        sel_addr  = sel ? p1_addr_i  : p0_addr_i;
        sel_wdata = sel ? p1_wdata_i : p0_wdata_i;
        case (sel_size)
            2'b00:   sel_n = 3'd1;
            2'b01:   sel_n = 3'd2;
            default: sel_n = 3'd4;
        endcase
        // widened so an address near 2^32 cannot wrap back into range
        sel_end = {1'b0, sel_addr} + 33'(sel_n) - 33'd1;
        sel_err = (sel_size == 2'b11)
                | ((sel_size == 2'b01) && sel_addr[0])
                | ((sel_size == 2'b10) && (sel_addr[1:0] != 2'b00))
                | (sel_end >= 33'(DEPTH));
    end

    assign xfer_last = ({1'b0, cnt_q} == (n_q - 3'd1));
    assign byte_idx  = 2'(n_q - 3'd1 - {1'b0, cnt_q});

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and all outputs, decoded from registered state only
    always_comb begin
        state_d     = state_q;
        busy_o      = (state_q != IDLE);
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;
        p0_ack_o    = 1'b0;
        p0_err_o    = 1'b0;
        p0_rdata_o  = '0;
        p1_ack_o    = 1'b0;
        p1_err_o    = 1'b0;
        p1_rdata_o  = '0;
        case (state_q)
            IDLE: begin
                if (req_any) begin
                    state_d = sel_err ? DONE : XFER;
                end
            end
            XFER: begin
                mem_addr_o = addr_q + ADDR_W'(cnt_q);
                mem_we_o   = we_q;
                if (we_q) begin
                    mem_wdata_o = wdata_q[{byte_idx, 3'b000} +: 8];
                end
                if (xfer_last) begin
                    state_d = we_q ? DONE : RTAIL;
                end
            end
            RTAIL: begin
                state_d = DONE;
            end
            DONE: begin
                if (gnt_q) begin
                    p1_ack_o   = 1'b1;
                    p1_err_o   = err_q;
                    p1_rdata_o = rdata_q;
                end else begin
                    p0_ack_o   = 1'b1;
                    p0_err_o   = err_q;
                    p0_rdata_o = rdata_q;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, byte counter, read assembly and grant history
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            n_q     <= 3'd1;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_any) begin
                        gnt_q   <= sel;
                        we_q    <= sel_we;
                        err_q   <= sel_err;
                        n_q     <= sel_n;
                        cnt_q   <= '0;
                        addr_q  <= sel_addr[ADDR_W-1:0];
                        wdata_q <= sel_wdata;
                        rdata_q <= '0;
                    end
                end
                XFER: begin
                    cnt_q <= cnt_q + 2'd1;
                    // memory data lags the address by one cycle
                    if (!we_q && (cnt_q != 2'd0)) begin
                        rdata_q <= {rdata_q[23:0], mem_rdata_i};
                    end
                end
                RTAIL: begin
                    rdata_q <= {rdata_q[23:0], mem_rdata_i};
                end
                DONE: begin
                    last_q <= gnt_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: byte memory model, reference
// model of memory contents / latency / error rules, directed and random tests.
module tb_data_mem_arbiter;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [1:0]  p0_size, p1_size;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ack, p0_err, p1_ack, p1_err;
    logic [31:0] p0_rdata, p1_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;
    logic        preload;

    logic [7:0]  mem     [DEPTH];
    logic [7:0]  ref_mem [DEPTH];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int we_cnt = 0;
    int both_ack = 0;
    int ack_port [$];
    int ack_cyc  [$];

    data_mem_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk_i(clk), .reset_i(reset),
        .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_size_i(p0_size),
        .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
        .p0_ack_o(p0_ack), .p0_err_o(p0_err), .p0_rdata_o(p0_rdata),
        .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_size_i(p1_size),
        .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
        .p1_ack_o(p1_ack), .p1_err_o(p1_err), .p1_rdata_o(p1_rdata),
        .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .busy_o(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte memory with registered read
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= ref_mem[i];
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    // Observe write strobes and acknowledges mid-cycle
    always @(negedge clk) begin
        if (mem_we) we_cnt++;
        if (p0_ack && p1_ack) both_ack++;
        if (p0_ack) begin ack_port.push_back(0); ack_cyc.push_back(cyc); end
        if (p1_ack) begin ack_port.push_back(1); ack_cyc.push_back(cyc); end
    end

    // ---------------- reference model ----------------
    function automatic int ref_n(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit ref_err(input logic [1:0] size, input logic [31:0] addr);
        longint a = longint'(addr);
        if (size == 2'd3) return 1'b1;
        if (a % ref_n(size) != 0) return 1'b1;
        return (a + ref_n(size) - 1) >= DEPTH;
    endfunction

    function automatic int ref_lat(input bit we, input logic [1:0] size, input logic [31:0] addr);
        if (ref_err(size, addr)) return 1;
        return we ? ref_n(size) + 1 : ref_n(size) + 2;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic [31:0] addr);
        logic [31:0] v = 0;
        if (ref_err(size, addr)) return 0;
        for (int k = 0; k < ref_n(size); k++) v = v * 256 + 32'(ref_mem[int'(addr) + k]);
        return v;
    endfunction

    task automatic ref_store(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
        int n = ref_n(size);
        if (ref_err(size, addr)) return;
        for (int k = 0; k < n; k++) ref_mem[int'(addr) + k] = 8'((wdata >> (8 * (n - 1 - k))) % 256);
    endtask

    // ---------------- stimulus helper ----------------
    // Entered and left at #1 after a rising edge with the DUT idle.
    task automatic access(input bit port, input bit we, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output int lat, output bit err, output logic [31:0] rdata);
        lat = -1; err = 1'b0; rdata = '0;
        if (port) begin
            p1_we = we; p1_size = size; p1_addr = addr; p1_wdata = wdata; p1_req = 1'b1;
        end else begin
            p0_we = we; p0_size = size; p0_addr = addr; p0_wdata = wdata; p0_req = 1'b1;
        end
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (port ? p1_ack : p0_ack) begin
                lat = c;
                err = port ? p1_err : p0_err;
                rdata = port ? p1_rdata : p0_rdata;
                break;
            end
        end
        p0_req = 1'b0; p1_req = 1'b0;
        @(posedge clk); #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; preload = 1'b1;
        repeat (3) @(posedge clk);
        #1; preload = 1'b0;
        checks++;
        if ({p0_ack, p0_err, p1_ack, p1_err, mem_we, busy} !== 6'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 000000",
                               {p0_ack, p0_err, p1_ack, p1_err, mem_we, busy});
        end
        checks++;
        if (mem_addr !== '0 || mem_wdata !== '0) begin
            errors++; $display("FAIL reset_mem_bus: got addr=%h wdata=%h expected 0", mem_addr, mem_wdata);
        end
        checks++;
        if (p0_rdata !== '0 || p1_rdata !== '0) begin
            errors++; $display("FAIL reset_rdata: got %h/%h expected 0", p0_rdata, p1_rdata);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_sb();
        int lat; bit err; logic [31:0] rd; int w0;
        w0 = we_cnt;
        access(0, 1, 2'd0, 32'd8, 32'h12345678, lat, err, rd);
        ref_store(2'd0, 32'd8, 32'h12345678);
        checks++;
        if (mem[8] !== 8'h78 || mem[7] !== ref_mem[7] || mem[9] !== ref_mem[9]) begin
            errors++; $display("FAIL sb_data: got %h %h %h expected %h 78 %h",
                               mem[7], mem[8], mem[9], ref_mem[7], ref_mem[9]);
        end
        checks++;
        if (we_cnt - w0 != 1) begin
            errors++; $display("FAIL sb_we_cycles: got %0d expected 1", we_cnt - w0);
        end
        checks++;
        if (lat != 2 || err !== 1'b0) begin
            errors++; $display("FAIL sb_ack: got lat=%0d err=%b expected lat=2 err=0", lat, err);
        end
    endtask

    task automatic test_sw_lw();
        int lat; bit err; logic [31:0] rd;
        access(0, 1, 2'd2, 32'h10, 32'hDEADBEEF, lat, err, rd);
        ref_store(2'd2, 32'h10, 32'hDEADBEEF);
        checks++;
        if ({mem[16], mem[17], mem[18], mem[19]} !== 32'hDEADBEEF || lat != 5) begin
            errors++; $display("FAIL sw_bytes: got %h%h%h%h lat=%0d expected DEADBEEF lat=5",
                               mem[16], mem[17], mem[18], mem[19], lat);
        end
        access(0, 0, 2'd2, 32'h10, 32'h0, lat, err, rd);
        checks++;
        if (rd !== ref_load(2'd2, 32'h10) || lat != 6 || err !== 1'b0) begin
            errors++; $display("FAIL lw_read: got %h lat=%0d err=%b expected %h lat=6 err=0",
                               rd, lat, err, ref_load(2'd2, 32'h10));
        end
        access(1, 0, 2'd1, 32'h12, 32'h0, lat, err, rd);
        checks++;
        if (rd !== 32'h0000BEEF || lat != 4 || err !== 1'b0) begin
            errors++; $display("FAIL lh_read: got %h lat=%0d err=%b expected 0000beef lat=4 err=0",
                               rd, lat, err);
        end
    endtask

    task automatic test_arbitration();
        int base, c0, got;
        test_reset();
        base = ack_port.size();
        p0_we = 1; p0_size = 0; p0_addr = 32'h40; p0_wdata = 32'hA5;
        p1_we = 1; p1_size = 0; p1_addr = 32'h41; p1_wdata = 32'h5A;
        c0 = cyc;
        p0_req = 1; p1_req = 1;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (ack_port.size() >= base + 4) break;
        end
        p0_req = 0; p1_req = 0;
        @(posedge clk); #1;
        got = ack_port.size() - base;
        checks++;
        if (got != 4) begin
            errors++; $display("FAIL arb_count: got %0d acks expected 4", got);
        end else begin
            for (int k = 0; k < 4; k++) begin
                checks++;
                if (ack_port[base + k] != (k % 2) ||
                    ack_cyc[base + k] - c0 != 2 + 3 * k) begin
                    errors++; $display("FAIL arb_grant%0d: got port=%0d at +%0d expected port=%0d at +%0d",
                                       k, ack_port[base + k], ack_cyc[base + k] - c0, k % 2, 2 + 3 * k);
                end
            end
        end
        ref_store(0, 32'h40, 32'hA5);
        ref_store(0, 32'h41, 32'h5A);
        checks++;
        if (mem[8'h40] !== ref_mem[8'h40] || mem[8'h41] !== ref_mem[8'h41] || both_ack != 0) begin
            errors++; $display("FAIL arb_data: got %h %h both=%0d expected a5 5a both=0",
                               mem[8'h40], mem[8'h41], both_ack);
        end
    endtask

    task automatic test_errors();
        logic [1:0]  sz [7] = '{2'd1, 2'd2, 2'd0, 2'd3, 2'd2, 2'd1, 2'd2};
        logic [31:0] ad [7] = '{32'h9, 32'h12, 32'h100, 32'h4, 32'hFE, 32'hFF, 32'hFFFFFFFC};
        int lat; bit err; logic [31:0] rd; int w0;
        for (int k = 0; k < 7; k++) begin
            w0 = we_cnt;
            access(k % 2, (k % 3) == 2, sz[k], ad[k], 32'hFFFFFFFF, lat, err, rd);
            checks++;
            if (err !== ref_err(sz[k], ad[k]) || lat != 1 || rd !== 32'h0 || we_cnt != w0) begin
                errors++; $display("FAIL err_case%0d: got err=%b lat=%0d rdata=%h we=%0d expected err=1 lat=1 rdata=0 we=0",
                                   k, err, lat, rd, we_cnt - w0);
            end
        end
    endtask

    task automatic test_reset_mid();
        int a0; int lat; bit err; logic [31:0] rd;
        a0 = ack_port.size();
        p0_we = 1; p0_size = 2; p0_addr = 32'h20; p0_wdata = 32'hAABBCCDD; p0_req = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1; p0_req = 0;
        @(posedge clk); #1;
        reset = 0;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rst_busy: got %b expected 0", busy);
        end
        repeat (4) @(posedge clk);
        #1;
        ref_mem[8'h20] = 8'hAA; ref_mem[8'h21] = 8'hBB;
        checks++;
        if ({mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]} !==
            {ref_mem[8'h20], ref_mem[8'h21], ref_mem[8'h22], ref_mem[8'h23]}) begin
            errors++; $display("FAIL rst_bytes: got %h%h%h%h expected %h%h%h%h",
                               mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23],
                               ref_mem[8'h20], ref_mem[8'h21], ref_mem[8'h22], ref_mem[8'h23]);
        end
        checks++;
        if (ack_port.size() != a0) begin
            errors++; $display("FAIL rst_noack: got %0d acks expected 0", ack_port.size() - a0);
        end
        access(1, 1, 2'd0, 32'h22, 32'h3C, lat, err, rd);
        ref_store(2'd0, 32'h22, 32'h3C);
        checks++;
        if (lat != 2 || err !== 1'b0 || mem[8'h22] !== 8'h3C) begin
            errors++; $display("FAIL rst_next: got lat=%0d err=%b byte=%h expected lat=2 err=0 byte=3c",
                               lat, err, mem[8'h22]);
        end
    endtask

    task automatic test_random();
        int lat; bit err; logic [31:0] rd; int w0;
        bit port, we; logic [1:0] sz; logic [31:0] ad, wd, exp_rd;
        for (int k = 0; k < 80; k++) begin
            port = 1'($urandom_range(0, 1));
            we   = 1'($urandom_range(0, 1));
            sz   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 5) == 0) ad = 32'($urandom_range(0, 300));
            else ad = 32'($urandom_range(0, DEPTH - 1)) & ~32'(ref_n(sz) - 1);
            wd = $urandom;
            exp_rd = we ? 32'h0 : ref_load(sz, ad);
            w0 = we_cnt;
            access(port, we, sz, ad, wd, lat, err, rd);
            if (we) ref_store(sz, ad, wd);
            checks++;
            if (lat != ref_lat(we, sz, ad) || err !== ref_err(sz, ad)) begin
                errors++; $display("FAIL rnd%0d_ack: got lat=%0d err=%b expected lat=%0d err=%b",
                                   k, lat, err, ref_lat(we, sz, ad), ref_err(sz, ad));
            end
            checks++;
            if (rd !== exp_rd) begin
                errors++; $display("FAIL rnd%0d_rdata: got %h expected %h", k, rd, exp_rd);
            end
            checks++;
            if (we_cnt - w0 != ((we && !ref_err(sz, ad)) ? ref_n(sz) : 0)) begin
                errors++; $display("FAIL rnd%0d_we: got %0d write cycles", k, we_cnt - w0);
            end
        end
    endtask

    initial begin
        reset = 1; preload = 0;
        p0_req = 0; p0_we = 0; p0_size = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_we = 0; p1_size = 0; p1_addr = 0; p1_wdata = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'($urandom);
        test_reset();
        test_sb();
        test_sw_lw();
        test_arbitration();
        test_errors();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
